// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps per op.
// Optional MULDIV_FAST_MUL_EN: ops 0-3 use a single-cycle 64-bit multiplier instead.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out,
   output logic        wb_en,
   output logic [1:0]  state_dbg
);
   // Handshake: start is accepted only while busy=0; done is a one-cycle result-valid pulse.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [2:0]  op_q;
   logic [31:0] acc_q, acc_nx;
   logic [31:0] lo_q, lo_nx;
   logic [31:0] mcand_q;
   logic [31:0] dvd_q;
   logic        qneg_q, rneg_q, divz_q;

   logic        accept, last_step, fast_op;
   logic        a_signed, b_signed, an, bn;
   logic [31:0] ma, mb;
   logic [31:0] fast_res;
   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic [31:0] div_diff;
   logic        div_ge;
   logic [63:0] prod, prod_n;
   logic [31:0] q_fix, r_fix, fin;

   assign accept    = (state_q == IDLE) && start;
   assign last_step = (state_q == RUN) && (cnt_q == 5'd31);

   // Operand signedness and magnitudes; everything downstream works on magnitudes.
   always_comb begin
      a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
      b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      an       = a_signed & rs1_data[31];
      bn       = b_signed & rs2_data[31];
      ma       = an ? (~rs1_data + 32'd1) : rs1_data;
      mb       = bn ? (~rs2_data + 32'd1) : rs2_data;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [63:0] fa, fb, fprod;
   assign fa       = {{32{an}}, rs1_data};
   assign fb       = {{32{bn}}, rs2_data};
   assign fprod    = fa * fb;
   assign fast_op  = ~op[2];
   assign fast_res = (op == 3'd0) ? fprod[31:0] : fprod[63:32];
`else
   assign fast_op  = 1'b0;
   assign fast_res = 32'd0;
`endif

   // One iteration: multiply keeps {acc,lo} as the shifting product, divide keeps
   // acc as the partial remainder and lo as dividend-in / quotient-out.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
      div_sh   = {acc_q, lo_q[31]};
      div_ge   = div_sh >= {1'b0, mcand_q};
      div_diff = div_sh[31:0] - mcand_q;
      if (op_q[2]) begin
         acc_nx = div_ge ? div_diff : div_sh[31:0];
         lo_nx  = {lo_q[30:0], div_ge};
      end else begin
         acc_nx = mul_sum[32:1];
         lo_nx  = {mul_sum[0], lo_q[31:1]};
      end
   end

   always_comb begin
      prod   = {acc_nx, lo_nx};
      prod_n = qneg_q ? (~prod + 64'd1) : prod;
      q_fix  = qneg_q ? (~lo_nx + 32'd1) : lo_nx;
      r_fix  = rneg_q ? (~acc_nx + 32'd1) : acc_nx;
      case (op_q)
         3'd0:        fin = prod_n[31:0];
         3'd1, 3'd2,
         3'd3:        fin = prod_n[63:32];
         3'd4, 3'd5:  fin = divz_q ? 32'hFFFF_FFFF : q_fix;
         default:     fin = divz_q ? dvd_q : r_fix;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = fast_op ? DONE : RUN;
         RUN:     if (cnt_q == 5'd31) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         op_q    <= 3'd0;
         acc_q   <= 32'd0;
         lo_q    <= 32'd0;
         mcand_q <= 32'd0;
         dvd_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         divz_q  <= 1'b0;
         result  <= 32'd0;
         rd_out  <= 5'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op;
            rd_out  <= rd_in;
            cnt_q   <= 5'd0;
            acc_q   <= 32'd0;
            dvd_q   <= rs1_data;
            divz_q  <= (rs2_data == 32'd0);
            qneg_q  <= an ^ bn;
            rneg_q  <= an;
            lo_q    <= op[2] ? ma : mb;
            mcand_q <= op[2] ? mb : ma;
            if (fast_op) result <= fast_res;
         end else if (state_q == RUN) begin
            acc_q <= acc_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q + 5'd1;
            if (last_step) result <= fin;
         end
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign wb_en     = done && (rd_out != 5'd0);
   assign state_dbg = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences,
// and random ops against a plain-arithmetic reference model.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [2:0]  op;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_in;
   logic        busy, done, wb_en;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic [1:0]  state_dbg;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[16];

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
      .busy(busy), .done(done), .result(result), .rd_out(rd_out),
      .wb_en(wb_en), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
      return o[2] ? 33 : 1;
`else
      return 33;
`endif
   endfunction

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // Accept one op, scramble the inputs, then wait for done and check everything.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input string name);
      int n;
      @(negedge clk);
      op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
      n = 1;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_latency"}, n, exp_lat(o));
      chk({name, "_result"}, result, exp);
      chk({name, "_rd_out"}, {27'd0, rd_out}, {27'd0, rd});
      chk({name, "_wb_en"}, {31'd0, wb_en}, {31'd0, rd != 5'd0});
      @(posedge clk); #1;
      chk({name, "_done_drop"}, {31'd0, done}, 32'd0);
      chk({name, "_hold"}, result, exp);
   endtask

   initial begin
      int dones;
      logic prev_done;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
      vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
      vecs[3]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd3,  32'h8000_0000};
      vecs[4]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd4,  32'h0000_0000};
      vecs[5]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD};
      vecs[6]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF};
      vecs[7]  = '{3'd5, 32'd100,        32'd0,         5'd8,  32'hFFFF_FFFF};
      vecs[8]  = '{3'd7, 32'd100,        32'd0,         5'd9,  32'h0000_0064};
      vecs[9]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd10, 32'hFFFF_FFFF};
      vecs[10] = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14};
      vecs[11] = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2};
      vecs[12] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         5'd13, 32'hFFFF_FFFF};
      vecs[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         5'd14, 32'hFFFF_FFFB};
      vecs[14] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd15, 32'd1};
      vecs[15] = '{3'd0, 32'd3,          32'd4,         5'd0,  32'd12};

      rst = 1'b1; start = 1'b0; op = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_rd_out", {27'd0, rd_out}, 32'd0);

      // reset wins over a simultaneous start
      @(negedge clk);
      start = 1'b1; op = 3'd5; rs1_data = 32'd9; rs2_data = 32'd2; rd_in = 5'd3;
      @(posedge clk); #1;
      chk("rst_over_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0; start = 1'b0;

      foreach (vecs[i])
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, $sformatf("vec%0d", i));

      // second start mid-RUN and a start during the done cycle are both ignored
      @(negedge clk);
      op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      op = 3'd0; rs1_data = 32'd7; rs2_data = 32'd3; rd_in = 5'd4; start = 1'b1;
      dones = 0;
      prev_done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (prev_done) chk("ignore_in_done_busy", {31'd0, busy}, 32'd0);
         prev_done = done;
         if (done) begin
            dones++;
            chk("ignore_result", result, 32'd14);
            chk("ignore_rd_out", {27'd0, rd_out}, 32'd9);
            op = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5; rd_in = 5'd1; start = 1'b1;
         end
      end
      chk("ignore_done_count", dones, 32'd1);

      // reset at RUN cycle 20 abandons the op
      @(negedge clk);
      op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd10; rd_in = 5'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
      chk("midrun_rst_done", {31'd0, done}, 32'd0);
      chk("midrun_rst_result", result, 32'd0);
      chk("midrun_rst_rd_out", {27'd0, rd_out}, 32'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || wb_en) dones++;
      end
      chk("midrun_rst_no_done", dones, 32'd0);
      do_op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, "rd0_after_rst");

      // random ops against the reference model
      for (int i = 0; i < 150; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 4))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
            3: begin ra = -32'($urandom_range(0, 50)); rb = -32'($urandom_range(1, 9)); end
            default: ;
         endcase
         exp_q.push_back(model(ro, ra, rb));
         do_op(ro, ra, rb, 5'($urandom_range(0, 31)), exp_q.pop_front(), $sformatf("rand%0d_op%0d", i, ro));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin one operation; sampled only while busy=0.
REQ-004 SHALL have port op, input, 3 bits: RV32M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-005 SHALL have ports rs1_data and rs2_data, input, 32 bits each: operands taken from register-file readdata1/readdata2.
REQ-006 SHALL have port rd_in, input, 5 bits: destination register index, captured with operands.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after acceptance through the done cycle inclusive.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 SHALL have port result, output, 32 bits: value for register-file writedata.
REQ-010 SHALL have port rd_out, output, 5 bits: captured rd_in, for register-file writereg.
REQ-011 SHALL have port wb_en, output, 1 bit: register-file regwrite strobe; equals done AND (rd_out != 0).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; transitions IDLE->RUN on start, RUN->DONE when the iteration counter reaches 31, DONE->IDLE unconditionally.
REQ-013 SHALL latch op, rs1_data, rs2_data, rd_in on the edge where start=1 in IDLE; later input changes SHALL NOT affect the operation.
REQ-014 SHALL ignore start while busy=1, including in the DONE cycle; there is no queueing.
REQ-015 SHALL use a 5-bit counter with 32 RUN cycles of one shift-add (multiply) or restoring shift-subtract (divide) step each.
REQ-016 SHALL assert done exactly 33 cycles after the accepting edge, with uniform latency for every op and operand value.
REQ-017 SHALL return the low 32 bits of the 64-bit product for MUL, and the high 32 bits for MULH (s×s), MULHSU (s×u), and MULHU (u×u).
REQ-018 SHALL compute DIV/REM with truncation toward zero, remainder sign equal to dividend sign, via magnitude division plus sign fix-up.
REQ-019 SHALL, on divide-by-zero, return 0xFFFFFFFF for DIV/DIVU and the dividend for REM/REMU, with latency unchanged.
REQ-020 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, return 0x80000000, and return 0 for the matching REM.
REQ-021 SHALL hold result and rd_out stable after done until the next accepted start.
REQ-022 SHALL pulse done when rd_in=0, but SHALL keep wb_en low.

Reset
REQ-023 SHALL, while rst=1 at an edge, force state IDLE, counter 0, busy 0, done 0, wb_en 0, result 0x00000000, rd_out 0.
REQ-024 SHALL, on rst mid-RUN or in DONE, abandon the operation with no done or wb_en pulse; reset SHALL take priority over start on the same edge.

Configuration
REQ-025 SHALL, when macro MULDIV_FAST_MUL_EN is defined, compute ops 0-3 with a single-cycle 64-bit multiplier, skip RUN (IDLE->DONE), and assert done 1 cycle after acceptance; divide ops SHALL be unchanged.
REQ-026 SHALL, when MULDIV_FAST_MUL_EN is undefined, compute all ops iteratively with 33-cycle latency and instantiate no hardware multiplier.

Verification
REQ-027 SHALL cover: MUL with rs1=7, rs2=0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out 5, done and wb_en high 33 cycles after start (1 cycle with MULDIV_FAST_MUL_EN).
REQ-028 SHALL cover: MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE, and MULH on the same operands -> 0x00000000.
REQ-029 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-030 SHALL cover: DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100 (0x64), each at 33-cycle latency.
REQ-031 SHALL cover: a second start 10 cycles into RUN -> ignored, exactly one done pulse, result from the first operands.
REQ-032 SHALL cover: rst pulse at RUN cycle 20 -> busy 0 next cycle, no done or wb_en, result 0; then rd_in=0 op -> done pulses with wb_en 0.
